// File: rtl/seg_display_pkg.sv
// Shared types and constants for the multiplexed seven-segment display controller.
// Segment patterns are active-low with bit0 = segment a through bit6 = segment g.
package seg_display_pkg;

    typedef logic [3:0] nibble_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Hex glyphs 0-9, then A b C d E F
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational nibble to active-low seven-segment decoder driven from the package table.
module seg_hex_dec
    import seg_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_segments
);

    assign o_segments = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed seven-segment display controller: per-digit dwell timing, double-buffered
// digit data swapped at frame boundaries, leading-zero suppression and PWM dimming.
// Optional blinking of selected digits is built when SEG_DISPLAY_BLINK_EN is defined.
module seg_display_ctrl
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_OVERFLOW = 2**19 - 1,
    parameter int BRIGHT_W         = 4,
    parameter int BLINK_LOG2       = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_DIGITS*4-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    lz_en,
`ifdef SEG_DISPLAY_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [NUM_DIGITS-1:0]   digit_select,
    output logic [6:0]              led_select,
    output logic                    dp_n,
    output logic                    frame_start
);

    localparam int DWELL_W = (REFRESH_OVERFLOW > 0) ? $clog2(REFRESH_OVERFLOW + 1) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    logic [DWELL_W-1:0]      r_dwellCount;
    logic [IDX_W-1:0]        r_index;
    logic [BRIGHT_W-1:0]     r_pwmCount;
    logic                    r_frameStart;

    logic [NUM_DIGITS*4-1:0] r_pendDigits;
    logic [NUM_DIGITS-1:0]   r_pendDp;
    logic                    r_pendValid;
    logic [NUM_DIGITS*4-1:0] r_activeDigits;
    logic [NUM_DIGITS-1:0]   r_activeDp;

    logic [NUM_DIGITS-1:0]   r_digitSelect;
    logic [6:0]              r_ledSelect;
    logic                    r_dpN;

    logic                    w_dwellDone;
    logic                    w_lastDigit;
    logic                    w_wrap;
    nibble_t                 w_curNibble;
    logic [6:0]              w_segments;
    logic                    w_upperZero;
    logic                    w_lzBlank;
    logic                    w_pwmOn;
    logic                    w_blinkBlank;

    assign w_dwellDone = (r_dwellCount == DWELL_W'(REFRESH_OVERFLOW));
    assign w_lastDigit = (r_index == IDX_W'(NUM_DIGITS - 1));
    assign w_wrap      = w_dwellDone && w_lastDigit;

    // Dwell counter and digit index: the index advances each time the dwell counter wraps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dwellCount <= '0;
            r_index      <= '0;
        end else if (w_dwellDone) begin
            r_dwellCount <= '0;
            r_index      <= w_lastDigit ? '0 : r_index + 1'b1;
        end else begin
            r_dwellCount <= r_dwellCount + 1'b1;
        end
    end

    // Free-running PWM counter used for brightness dimming
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pwmCount <= '0;
        end else begin
            r_pwmCount <= r_pwmCount + 1'b1;
        end
    end

    // Frame-start pulse, high for the first cycle of digit 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frameStart <= 1'b0;
        end else begin
            r_frameStart <= w_wrap;
        end
    end

    // Double buffer: loads land in pending, pending moves to active only at a frame wrap so a
    // frame never shows a mix of old and new digits; a load on the wrap itself stays pending
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pendDigits   <= '0;
            r_pendDp       <= '0;
            r_pendValid    <= 1'b0;
            r_activeDigits <= '0;
            r_activeDp     <= '0;
        end else begin
            if (w_wrap && r_pendValid) begin
                r_activeDigits <= r_pendDigits;
                r_activeDp     <= r_pendDp;
            end
            if (load) begin
                r_pendDigits <= digits;
                r_pendDp     <= dp;
                r_pendValid  <= 1'b1;
            end else if (w_wrap) begin
                r_pendValid  <= 1'b0;
            end
        end
    end

`ifdef SEG_DISPLAY_BLINK_EN
    logic [BLINK_LOG2:0] r_blinkCount;

    // Frame counter whose top bit is the blink phase, toggling every 2**BLINK_LOG2 frames
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blinkCount <= '0;
        end else if (w_wrap) begin
            r_blinkCount <= r_blinkCount + 1'b1;
        end
    end

    assign w_blinkBlank = r_blinkCount[BLINK_LOG2] && blink_mask[r_index];
`else
    // BLINK_LOG2 only shapes the blink counter, so without blinking it is left unconsumed
    logic w_unusedBlink;
    assign w_unusedBlink = ^BLINK_LOG2;
    assign w_blinkBlank  = 1'b0;
`endif

    // A digit is leading-zero blanked when it and every more-significant digit are zero
    assign w_curNibble = nibble_t'(r_activeDigits >> {r_index, 2'b00});
    assign w_upperZero = ((r_activeDigits >> {r_index, 2'b00}) == '0);
    assign w_lzBlank   = lz_en && (r_index != '0) && w_upperZero;
    assign w_pwmOn     = (brightness == '1) || (r_pwmCount < brightness);

    seg_hex_dec u_hexDec (
        .i_nibble   (w_curNibble),
        .o_segments (w_segments)
    );

    // Registered drive: dimmed or blink-blanked digits turn everything off in the same cycle,
    // while a leading-zero blanked digit keeps its anode so its decimal point can still light
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_digitSelect <= '1;
            r_ledSelect   <= SEG_BLANK;
            r_dpN         <= 1'b1;
        end else if (!w_pwmOn || w_blinkBlank) begin
            r_digitSelect <= '1;
            r_ledSelect   <= SEG_BLANK;
            r_dpN         <= 1'b1;
        end else begin
            r_digitSelect <= ~(NUM_DIGITS'(1) << r_index);
            r_ledSelect   <= w_lzBlank ? SEG_BLANK : w_segments;
            r_dpN         <= ~r_activeDp[r_index];
        end
    end

    assign digit_select = r_digitSelect;
    assign led_select   = r_ledSelect;
    assign dp_n         = r_dpN;
    assign frame_start  = r_frameStart;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl with a short dwell so whole frames run quickly.
// The reference model derives digit index, PWM phase and frame number from the cycle count
// since reset release and picks the displayed data from a log of time-stamped loads.
module tb_seg_display_ctrl;

    localparam int ND    = 4;
    localparam int OVF   = 3;
    localparam int BW    = 4;
    localparam int BL    = 1;
    localparam int DWELL = OVF + 1;
    localparam int FRAME = DWELL * ND;

    logic            clk = 1'b0;
    logic            reset;
    logic [ND*4-1:0] digits;
    logic [ND-1:0]   dp;
    logic            load;
    logic [BW-1:0]   brightness;
    logic            lz_en;
`ifdef SEG_DISPLAY_BLINK_EN
    logic [ND-1:0]   blink_mask;
`endif
    logic [ND-1:0]   digit_select;
    logic [6:0]      led_select;
    logic            dp_n;
    logic            frame_start;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int            loadCyc [$];
    logic [ND*4-1:0] loadDig [$];
    logic [ND-1:0]   loadDp  [$];

    seg_display_ctrl #(
        .NUM_DIGITS       (ND),
        .REFRESH_OVERFLOW (OVF),
        .BRIGHT_W         (BW),
        .BLINK_LOG2       (BL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .digits       (digits),
        .dp           (dp),
        .load         (load),
        .brightness   (brightness),
        .lz_en        (lz_en),
`ifdef SEG_DISPLAY_BLINK_EN
        .blink_mask   (blink_mask),
`endif
        .digit_select (digit_select),
        .led_select   (led_select),
        .dp_n         (dp_n),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    // Active-low glyph for a hex value, written from the lit-segment (active-high) patterns
    function automatic logic [6:0] glyph(input int v);
        logic [6:0] lit;
        case (v)
            0: lit = 7'h3F;  1: lit = 7'h06;  2: lit = 7'h5B;  3: lit = 7'h4F;
            4: lit = 7'h66;  5: lit = 7'h6D;  6: lit = 7'h7D;  7: lit = 7'h07;
            8: lit = 7'h7F;  9: lit = 7'h6F; 10: lit = 7'h77; 11: lit = 7'h7C;
           12: lit = 7'h39; 13: lit = 7'h5E; 14: lit = 7'h79; default: lit = 7'h71;
        endcase
        return ~lit;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // Predict the outputs registered at edge number cyc from the state of the cycle before it
    task automatic modelCycle();
        int slot, idx, pwm, frame;
        logic [ND*4-1:0] act;
        logic [ND-1:0]   actDp;
        logic            on, blank, lzb;
        logic [ND-1:0]   eDs;
        logic [6:0]      eSeg;
        logic            eDp;
        slot  = cyc - 1;
        idx   = (slot / DWELL) % ND;
        pwm   = slot % (1 << BW);
        frame = slot / FRAME;
        act   = '0;
        actDp = '0;
        for (int j = 0; j < loadCyc.size(); j++) begin
            if (loadCyc[j] < frame * FRAME - 1) begin
                act   = loadDig[j];
                actDp = loadDp[j];
            end
        end
        on    = (int'(brightness) == (1 << BW) - 1) || (pwm < int'(brightness));
        blank = 1'b0;
`ifdef SEG_DISPLAY_BLINK_EN
        if (((frame >> BL) & 1) == 1 && blink_mask[idx]) blank = 1'b1;
`endif
        lzb = lz_en && (idx > 0);
        for (int j = idx; j < ND; j++) begin
            if (act[j*4 +: 4] != 4'd0) lzb = 1'b0;
        end
        if (!on || blank) begin
            eDs  = '1;
            eSeg = 7'h7F;
            eDp  = 1'b1;
        end else begin
            eDs      = '1;
            eDs[idx] = 1'b0;
            eSeg     = lzb ? 7'h7F : glyph(int'(act[idx*4 +: 4]));
            eDp      = ~actDp[idx];
        end
        checkOutput("digit_select", 32'(digit_select), 32'(eDs));
        checkOutput("led_select",   32'(led_select),   32'(eSeg));
        checkOutput("dp_n",         32'(dp_n),         32'(eDp));
        checkOutput("frame_start",  32'(frame_start),  32'((cyc % FRAME) == 0));
    endtask

    task automatic stepCycle();
        @(negedge clk);
        cyc++;
        modelCycle();
        load = 1'b0;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    // Drive a one-cycle load during the current cycle and log it for the model
    task automatic applyStimulus(input logic [ND*4-1:0] d, input logic [ND-1:0] p);
        digits = d;
        dp     = p;
        load   = 1'b1;
        loadCyc.push_back(cyc);
        loadDig.push_back(d);
        loadDp.push_back(p);
    endtask

    task automatic randomCycles(input int n);
        logic [ND*4-1:0] d;
        for (int i = 0; i < n; i++) begin
            stepCycle();
            if ($urandom_range(0, 11) == 0) begin
                for (int j = 0; j < ND; j++)
                    d[j*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                applyStimulus(d, ND'($urandom));
            end
            if ($urandom_range(0, 39) == 0) brightness = BW'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) brightness = '1;
            if ($urandom_range(0, 49) == 0) lz_en = 1'($urandom);
`ifdef SEG_DISPLAY_BLINK_EN
            if ($urandom_range(0, 49) == 0) blink_mask = ND'($urandom);
`endif
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".digit_select"}, 32'(digit_select), 32'hF);
        checkOutput({tag, ".led_select"},   32'(led_select),   32'h7F);
        checkOutput({tag, ".dp_n"},         32'(dp_n),         32'h1);
        checkOutput({tag, ".frame_start"},  32'(frame_start),  32'h0);
    endtask

    task automatic restartLog();
        cyc = 0;
        loadCyc.delete();
        loadDig.delete();
        loadDp.delete();
    endtask

    initial begin
        reset      = 1'b0;
        digits     = '0;
        dp         = '0;
        load       = 1'b0;
        brightness = '1;
        lz_en      = 1'b0;
`ifdef SEG_DISPLAY_BLINK_EN
        blink_mask = 4'b0001;
`endif
        repeat (2) @(negedge clk);
        checkResetOutputs("power_on_reset");
        reset = 1'b1;
        restartLog();

        $display("[TB] hex glyph scan with 12AF");
        stepCycle();
        applyStimulus(16'h12AF, 4'b0000);
        runCycles(3 * FRAME);

        $display("[TB] leading-zero suppression");
        lz_en = 1'b1;
        applyStimulus(16'h0007, 4'b0100);
        runCycles(2 * FRAME);
        applyStimulus(16'h0000, 4'b0000);
        runCycles(2 * FRAME);
        lz_en = 1'b0;

        $display("[TB] brightness 4 then 0");
        applyStimulus(16'h8E3C, 4'b1010);
        brightness = 4'h4;
        runCycles(2 * FRAME);
        brightness = 4'h0;
        runCycles(2 * FRAME);
        brightness = '1;

        $display("[TB] load on the wrap cycle with data pending");
        while ((cyc % FRAME) != FRAME - 2) stepCycle();
        applyStimulus(16'h4321, 4'b0001);
        stepCycle();
        applyStimulus(16'h9876, 4'b1000);
        runCycles(3 * FRAME);

        $display("[TB] several loads within one frame");
        runCycles(3);
        applyStimulus(16'hABCD, 4'b0011);
        runCycles(5);
        applyStimulus(16'h5F0E, 4'b1100);
        runCycles(3 * FRAME);

        $display("[TB] randomized run");
        randomCycles(600);

        $display("[TB] reset mid-frame with a load pending");
        brightness = '1;
        while ((cyc % FRAME) != 6) stepCycle();
        applyStimulus(16'h7777, 4'b1111);
        #2 reset = 1'b0;
        #1 checkResetOutputs("async_reset");
        load = 1'b0;
        @(negedge clk);
        checkResetOutputs("held_reset");
        reset = 1'b1;
        restartLog();
        runCycles(3 * FRAME);

        randomCycles(400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: digit count, legal range 2..8.
REQ-002 SHALL have parameter REFRESH_OVERFLOW, default 2**19-1: terminal value of the per-digit dwell counter.
REQ-003 SHALL have parameter BRIGHT_W, default 4: width of the brightness code and of the PWM counter.
REQ-004 SHALL have parameter BLINK_LOG2, default 5: blink phase toggles every 2**BLINK_LOG2 frames.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; every register is clocked on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port digits, input, NUM_DIGITS*4 bits: hex nibble per digit; digit 0 is bits [3:0] and is the least significant.
REQ-008 SHALL have port dp, input, NUM_DIGITS bits: decimal point request per digit.
REQ-009 SHALL have port load, input, 1 bit: one-cycle strobe that captures digits and dp.
REQ-010 SHALL have port brightness, input, BRIGHT_W bits: PWM duty code, sampled live.
REQ-011 SHALL have port lz_en, input, 1 bit: leading-zero suppression enable, sampled live.
REQ-012 SHALL have port digit_select, output, NUM_DIGITS bits: one-hot-low digit anodes.
REQ-013 SHALL have port led_select, output, 7 bits: active-low segments, bit0=a through bit6=g.
REQ-014 SHALL have port dp_n, output, 1 bit: active-low decimal point.
REQ-015 SHALL have port frame_start, output, 1 bit: one-cycle pulse when the digit index wraps to 0.

Function
REQ-016 SHALL count the dwell counter 0..REFRESH_OVERFLOW; at the terminal value it wraps to 0 and the digit index increments, wrapping NUM_DIGITS-1 to 0.
REQ-017 SHALL capture digits and dp into a pending buffer and set a pending flag on load.
REQ-018 SHALL copy pending into the active buffer and clear the flag on the cycle the index wraps to 0, when the flag is set; frame_start pulses on the same cycle.
REQ-019 SHALL, when load coincides with the wrap, transfer the previously pending data, keep the new load data pending, and leave the flag set.
REQ-020 SHALL keep only the latest data when several loads occur within one frame.
REQ-021 SHALL decode 0-9 and A-F (10-15) as hex glyphs.
REQ-022 SHALL, with lz_en=1, blank digit i (i>0) when digit i and every more-significant active digit are 0; digit 0 is never suppressed; dp is still shown on suppressed digits.
REQ-023 SHALL run a free-running BRIGHT_W-bit PWM counter that wraps every 2**BRIGHT_W cycles.
REQ-024 SHALL enable the current digit when brightness is all-ones or PWM counter < brightness; brightness 0 keeps all anodes high.
REQ-025 SHALL make digit_select, led_select and dp_n registered outputs, valid one cycle after index, data or PWM change.
REQ-026 SHALL drive all segments and dp_n high in the same registered cycle that a digit is blanked or disabled, with no ghosting.

Reset
REQ-027 SHALL, on reset low, asynchronously clear the dwell counter, index, PWM counter, blink counter and pending flag, and zero the active and pending buffers.
REQ-028 SHALL, during reset, drive digit_select all-ones, led_select 7'h7F, dp_n 1 and frame_start 0.
REQ-029 SHALL, on reset release mid-frame, restart at digit 0 with dwell 0 and discard any pending load.

Configuration
REQ-030 SHALL, with SEG_DISPLAY_BLINK_EN defined, add input blink_mask (NUM_DIGITS bits) and a frame counter; while the blink phase is 1, masked digits are blanked, including dp; the phase is 0 after reset.
REQ-031 SHALL, without SEG_DISPLAY_BLINK_EN, have no blink_mask port and no blink logic; digits are never blink-blanked.

Structure
REQ-032 SHALL place the 16-entry segment pattern constant, the blank pattern and the nibble typedef in package seg_display_pkg.
REQ-033 SHALL use one sub-module, seg_hex_dec: a combinational nibble-to-active-low-7-segment decoder built from the package table.

Verification
REQ-034 Reset low mid-frame -> digit_select=4'hF, led_select=7'h7F and dp_n=1 immediately; after release, digit_select=4'hE is the first active value.
REQ-035 REFRESH_OVERFLOW=3, brightness=4'hF, load digits=16'h12AF -> from the next frame, anodes cycle E,D,B,7 every 4 cycles with segments F,A,2,1.
REQ-036 lz_en=1, digits=16'h0007 -> digits 3..1 blank, digit 0 shows 7; digits=16'h0000 -> only digit 0 shows 0.
REQ-037 brightness=4'h4 -> anode low for exactly 4 of every 16 cycles; brightness=0 -> anodes never low.
REQ-038 load asserted on the wrap cycle with a pending value outstanding -> old pending displays this frame, the new value displays the next frame, with one frame_start per wrap.
REQ-039 SEG_DISPLAY_BLINK_EN, BLINK_LOG2=1, blink_mask=4'b0001 -> digit 0 blank in frames 2-3 and 6-7, and visible in frames 0-1 and 4-5.
